muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start_valid  input  1  EXE stage requests an operation this cycle.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 src1  input  32  multiplicand or dividend.
REQ-007 src2  input  32  multiplier or divisor.
REQ-008 cancel  input  1  pipeline flush from write-back (syscall/eret).
REQ-009 busy  output  1  operation in progress; the pipeline stalls on it.
REQ-010 hilo_wen  output  1  one-cycle write strobe to the HI/LO registers.
REQ-011 hi_result  output  32  value for HI (product high word or remainder).
REQ-012 lo_result  output  32  value for LO (product low word or quotient).

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-014 IDLE with start_valid=1 and cancel=0 SHALL latch the operands and op, clear the 6-bit iteration counter, and go to MUL (op[1]=0) or DIV (op[1]=1); that edge is cycle 0.
REQ-015 start_valid outside IDLE SHALL be ignored, with no queuing.
REQ-016 Signed ops SHALL operate on operand magnitudes, recording the sign of each operand at acceptance.
REQ-017 MUL SHALL perform one shift-add step per cycle for 32 cycles on a 64-bit accumulator, then go to DONE.
REQ-018 DIV SHALL perform one restoring-division step per cycle for 32 cycles, then go to DONE.
REQ-019 Product sign fix: if op is MULT and the operand signs differ, the 64-bit product SHALL be negated.
REQ-020 Quotient sign fix: if op is DIV and the signs differ, the quotient SHALL be negated.
REQ-021 Remainder sign fix: if op is DIV, the remainder SHALL take the dividend's sign.
REQ-022 Divisor zero, both DIV and DIVU: LO=0xFFFFFFFF and HI=src1, overriding REQ-020 and REQ-021.
REQ-023 DIV 0x80000000/0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0 without error.
REQ-024 DONE SHALL last exactly one cycle (cycle 33 after acceptance), assert hilo_wen=1 with stable results, then return to IDLE.
REQ-025 busy SHALL be 1 in MUL and DIV, and 0 in IDLE and DONE.
REQ-026 A new start_valid is accepted no earlier than the IDLE cycle following DONE.
REQ-027 cancel=1 in MUL, DIV or DONE SHALL force IDLE at the next edge and suppress hilo_wen in that cycle; HI/LO SHALL be unchanged.
REQ-028 cancel and start_valid together in IDLE: the start SHALL be ignored.
REQ-029 hi_result and lo_result SHALL be registered and hold their last value outside DONE.

Reset
REQ-030 While reset=1: state IDLE, counter 0, busy 0, hilo_wen 0, hi_result 0, lo_result 0, operand registers 0.
REQ-031 Reset during MUL or DIV SHALL abort immediately with no hilo_wen pulse.

Structure
REQ-032 A shared package SHALL hold the op encodings, the FSM state encoding and WIDTH.
REQ-033 The iterative datapath (accumulator, shift-add and restore-subtract step) SHALL be one sub-module, muldiv_iter; the FSM, counter and sign handling stay in muldiv_ctrl.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hilo_wen at cycle 33, HI=0xFFFFFFFE, LO=0x00000001; busy high on cycles 1-32.
REQ-035 MULT 0xFFFFFFFD x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 DIVU 0x00000005 / 0 -> LO=0xFFFFFFFF, HI=0x00000005.
REQ-038 cancel at cycle 10 of a DIV -> no hilo_wen, busy=0 next cycle, next start accepted and its result correct at +33.
REQ-039 reset at cycle 20 of a MUL -> all outputs 0 immediately; start_valid held during DONE is not accepted.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the iterative multiply/divide unit: data width,
// op encodings, FSM state encoding and the operand-magnitude helper.
package muldiv_ctrl_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Index of the final iteration step (32 steps: 0..31).
  localparam logic [CNT_W-1:0] LAST_STEP = 6'd31;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: 64-bit accumulator doing one shift-add (multiply) or
// one restoring-subtract (divide) step per enabled cycle on unsigned operands.
module muldiv_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic [WIDTH-1:0] o_next_hi,
  output logic [WIDTH-1:0] o_next_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  // Multiply: r_lo holds the multiplier, shifted out LSB-first while the
  // partial product enters r_hi; the carry of the add lands in the top bit.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out of
  // the top and quotient bits in at the bottom.
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_fits  = ~w_diff[WIDTH];

  always_comb begin
    o_next_hi = r_hi;
    o_next_lo = r_lo;
    if (i_is_div) begin
      o_next_hi = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      o_next_lo = {r_lo[WIDTH-2:0], w_fits};
    end else begin
      o_next_hi = w_sum[WIDTH:1];
      o_next_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
      r_b  <= '0;
    end else if (i_load) begin
      r_hi <= '0;
      r_lo <= i_opa;
      r_b  <= i_opb;
    end else if (i_step) begin
      r_hi <= o_next_hi;
      r_lo <= o_next_lo;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller: FSM, step counter and sign
// handling around muldiv_iter; results are registered and strobed in DONE.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             hilo_wen,
  output logic [WIDTH-1:0] hi_result,
  output logic [WIDTH-1:0] lo_result,
  output logic [1:0]       o_dbg_state
);
  import muldiv_ctrl_pkg::*;

  // Handshake: start_valid is sampled only in IDLE with cancel low; there is
  // no ready signal, busy high means any start_valid is dropped, not queued.

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_sign1;
  logic             r_sign2;
  logic             r_div0;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_busy;
  logic             w_step;
  logic             w_last;
  logic             w_is_signed;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_next_hi;
  logic [WIDTH-1:0] w_next_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_accept    = (r_state == ST_IDLE) && start_valid && !cancel;
  assign w_busy      = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_step      = w_busy && !cancel;
  assign w_last      = w_step && (r_cnt == LAST_STEP);
  assign w_is_signed = ~op[0];
  assign w_mag1      = magnitude(src1, w_is_signed);
  assign w_mag2      = magnitude(src2, w_is_signed);

  muldiv_iter u_iter (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_step    (w_step),
    .i_is_div  (r_op[1]),
    .i_opa     (w_mag1),
    .i_opb     (w_mag2),
    .o_next_hi (w_next_hi),
    .o_next_lo (w_next_lo)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = op[1] ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: begin
        if (cancel)      w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sign fix-up is applied to the last step's combinational output so the
  // registered results are already final during the DONE cycle.
  assign w_prod     = {w_next_hi, w_next_lo};
  assign w_prod_fix = ((r_op == OP_MULT) && (r_sign1 ^ r_sign2)) ? -w_prod : w_prod;
  assign w_quo      = ((r_op == OP_DIV) && (r_sign1 ^ r_sign2)) ? -w_next_lo : w_next_lo;
  assign w_rem      = ((r_op == OP_DIV) && r_sign1) ? -w_next_hi : w_next_hi;

  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (r_op[1]) begin
      if (r_div0) begin
        w_res_hi = r_src1;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_sign1 <= 1'b0;
      r_sign2 <= 1'b0;
      r_div0  <= 1'b0;
      r_src1  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt   <= '0;
        r_op    <= op;
        r_sign1 <= w_is_signed & src1[WIDTH-1];
        r_sign2 <= w_is_signed & src2[WIDTH-1];
        r_div0  <= (src2 == '0);
        r_src1  <= src1;
      end else if (w_step) begin
        r_cnt <= r_cnt + 6'd1;
      end
      if (w_last) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign busy        = w_busy;
  assign hilo_wen    = (r_state == ST_DONE) && !cancel;
  assign hi_result   = r_hi;
  assign lo_result   = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: reset, each op with hand-computed results,
// divide-by-zero, overflow case, cancel, mid-operation reset, ignored starts.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start_valid;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  logic        busy;
  logic        hilo_wen;
  logic [31:0] hi_result;
  logic [31:0] lo_result;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_pass;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .cancel      (cancel),
    .busy        (busy),
    .hilo_wen    (hilo_wen),
    .hi_result   (hi_result),
    .lo_result   (lo_result),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation; the edge that latches it is cycle 0.
  task automatic run_op(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string name, input bit poke);
    int bad;
    bad = 0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s pre_busy got %b want 0", name, busy);
    else n_pass++;
    start_valid = 1'b1; op = t_op; src1 = a; src2 = b;
    step();
    start_valid = 1'b0; src1 = ~a; src2 = ~b;
    for (int k = 1; k <= 32; k++) begin
      if (busy !== 1'b1 || hilo_wen !== 1'b0) bad++;
      if (poke && k == 5) begin
        start_valid = 1'b1; op = ~t_op; src1 = 32'h1; src2 = 32'h1;
      end else begin
        start_valid = 1'b0;
      end
      step();
    end
    n_checks++;
    if (bad != 0) $display("FAIL %s busy_window got %0d bad cycles want 0", name, bad);
    else n_pass++;
    n_checks++;
    if (hilo_wen !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done_strobe got wen=%b busy=%b want wen=1 busy=0", name, hilo_wen, busy);
    else n_pass++;
    n_checks++;
    if (hi_result !== exp_hi) $display("FAIL %s hi got %h want %h", name, hi_result, exp_hi);
    else n_pass++;
    n_checks++;
    if (lo_result !== exp_lo) $display("FAIL %s lo got %h want %h", name, lo_result, exp_lo);
    else n_pass++;
    step();
    n_checks++;
    if (hilo_wen !== 1'b0 || dbg_state !== 2'd0 || hi_result !== exp_hi || lo_result !== exp_lo)
      $display("FAIL %s after_done got wen=%b st=%0d hi=%h lo=%h want wen=0 st=0 hi=%h lo=%h",
               name, hilo_wen, dbg_state, hi_result, lo_result, exp_hi, exp_lo);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b0; op = 2'b00; src1 = '0; src2 = '0; cancel = 1'b0;
    step();
    step();
    n_checks++;
    if (busy !== 1'b0 || hilo_wen !== 1'b0 || hi_result !== 32'h0 || lo_result !== 32'h0 || dbg_state !== 2'd0)
      $display("FAIL reset_state got busy=%b wen=%b hi=%h lo=%h st=%0d want all 0",
               busy, hilo_wen, hi_result, lo_result, dbg_state);
    else n_pass++;
    reset = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL reset_release got busy=%b st=%0d want 0 0", busy, dbg_state);
    else n_pass++;
  endtask

  task automatic test_mul();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", 1'b0);
    run_op(2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "mult_pos", 1'b0);
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_negdvd", 1'b0);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_negdvs", 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 1'b0);
    run_op(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu", 1'b0);
  endtask

  task automatic test_div_zero();
    run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "divu_zero", 1'b0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_zero", 1'b0);
  endtask

  task automatic test_cancel();
    int pulses;
    // Results from div_zero must survive the cancelled DIV.
    start_valid = 1'b1; op = 2'b10; src1 = 32'd100; src2 = 32'd3;
    step();
    start_valid = 1'b0;
    for (int k = 1; k < 10; k++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hilo_wen !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL cancel_div got busy=%b wen=%b st=%0d want 0 0 0", busy, hilo_wen, dbg_state);
    else n_pass++;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (hilo_wen !== 1'b0) pulses++;
      step();
    end
    n_checks++;
    if (pulses != 0 || hi_result !== 32'hFFFF_FFF0 || lo_result !== 32'hFFFF_FFFF)
      $display("FAIL cancel_quiet got pulses=%0d hi=%h lo=%h want 0 fffffff0 ffffffff",
               pulses, hi_result, lo_result);
    else n_pass++;
    run_op(2'b10, 32'd100, 32'd3, 32'h0000_0001, 32'h0000_0021, "after_cancel", 1'b0);
    // Cancel landing on the DONE cycle suppresses the strobe.
    start_valid = 1'b1; op = 2'b01; src1 = 32'd3; src2 = 32'd5;
    step();
    start_valid = 1'b0;
    for (int k = 1; k <= 32; k++) step();
    cancel = 1'b1;
    #1;
    n_checks++;
    if (hilo_wen !== 1'b0) $display("FAIL cancel_done got wen=%b want 0", hilo_wen);
    else n_pass++;
    step();
    cancel = 1'b0;
    n_checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0)
      $display("FAIL cancel_done_idle got st=%0d busy=%b want 0 0", dbg_state, busy);
    else n_pass++;
    // Start together with cancel in IDLE is dropped.
    start_valid = 1'b1; cancel = 1'b1; op = 2'b00; src1 = 32'd2; src2 = 32'd2;
    step();
    start_valid = 1'b0; cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL start_with_cancel got busy=%b st=%0d want 0 0", busy, dbg_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pulses;
    start_valid = 1'b1; op = 2'b00; src1 = 32'd9; src2 = 32'd9;
    step();
    start_valid = 1'b0;
    for (int k = 1; k < 20; k++) step();
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hilo_wen !== 1'b0 || hi_result !== 32'h0 || lo_result !== 32'h0 || dbg_state !== 2'd0)
      $display("FAIL reset_mid got busy=%b wen=%b hi=%h lo=%h st=%0d want all 0",
               busy, hilo_wen, hi_result, lo_result, dbg_state);
    else n_pass++;
    step();
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (hilo_wen !== 1'b0 || busy !== 1'b0) pulses++;
      step();
    end
    n_checks++;
    if (pulses != 0) $display("FAIL reset_mid_quiet got %0d active cycles want 0", pulses);
    else n_pass++;
  endtask

  task automatic test_start_in_done();
    start_valid = 1'b1; op = 2'b01; src1 = 32'd6; src2 = 32'd7;
    step();
    start_valid = 1'b0;
    for (int k = 1; k <= 32; k++) step();
    start_valid = 1'b1; op = 2'b11; src1 = 32'd10; src2 = 32'd2;
    #1;
    n_checks++;
    if (hilo_wen !== 1'b1 || lo_result !== 32'd42 || hi_result !== 32'd0)
      $display("FAIL done_result got wen=%b hi=%h lo=%h want 1 0 2a", hilo_wen, hi_result, lo_result);
    else n_pass++;
    step();
    start_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL start_in_done got busy=%b st=%0d want 0 0", busy, dbg_state);
    else n_pass++;
    step();
    n_checks++;
    if (busy !== 1'b0 || lo_result !== 32'd42)
      $display("FAIL start_in_done_late got busy=%b lo=%h want 0 2a", busy, lo_result);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "b2b_mul", 1'b1);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, "b2b_div", 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_cancel();
    test_reset_mid();
    test_start_in_done();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
